// File: rtl/count_max_monitor.sv
// Observer for a MAX_VALUE up-counter. It checks that the count sequence is legal and
// reports HIT, TIMEOUT or JUMP events one record at a time over a valid/ready handshake.
module count_max_monitor #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_VALUE = 8,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [1:0]       evt_code_o,
  output logic [7:0]       evt_cycles_o,
  output logic [7:0]       hit_total_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  localparam logic [1:0] EVT_NONE    = 2'd0;
  localparam logic [1:0] EVT_HIT     = 2'd1;
  localparam logic [1:0] EVT_TIMEOUT = 2'd2;
  localparam logic [1:0] EVT_JUMP    = 2'd3;

  localparam logic [WIDTH-1:0] MAX_C     = WIDTH'(MAX_VALUE);
  localparam logic [7:0]       TO_LAST_C = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [7:0]       cycles_q, cycles_d;
  logic             evt_valid_q, evt_valid_d;
  logic [1:0]       evt_code_q, evt_code_d;
  logic [7:0]       evt_cycles_q, evt_cycles_d;
  logic [7:0]       hit_total_q, hit_total_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] prev_inc;
  logic [7:0]       cycles_inc;
  logic             is_jump, is_hit, is_timeout, evt_fire;
  logic [1:0]       det_code;
  logic             handshake;

  // The increment wraps naturally at WIDTH bits, so 2**WIDTH-1 -> 0 is a legal step.
  assign prev_inc   = prev_q + WIDTH'(1);
  assign cycles_inc = (cycles_q == 8'hFF) ? 8'hFF : cycles_q + 8'd1;

  assign is_jump    = (count_i != prev_q) && (count_i != prev_inc);
  assign is_hit     = (count_i == MAX_C);
  assign is_timeout = (cycles_q == TO_LAST_C);
  assign evt_fire   = is_jump || is_hit || is_timeout;
  assign handshake  = evt_valid_q && evt_ready_i;

  always_comb begin
    det_code = EVT_NONE;
    if (is_jump) begin
      det_code = EVT_JUMP;
    end else if (is_hit) begin
      det_code = EVT_HIT;
    end else if (is_timeout) begin
      det_code = EVT_TIMEOUT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      cycles_q     <= '0;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= EVT_NONE;
      evt_cycles_q <= '0;
      hit_total_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      cycles_q     <= cycles_d;
      evt_valid_q  <= evt_valid_d;
      evt_code_q   <= evt_code_d;
      evt_cycles_q <= evt_cycles_d;
      hit_total_q  <= hit_total_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (count_i == '0) state_d = ST_TRACK;
      ST_TRACK:  if (evt_fire) state_d = ST_REPORT;
      ST_REPORT: if (handshake) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state; evt_code/evt_cycles are frozen for the whole REPORT stay.
  always_comb begin
    prev_d       = prev_q;
    cycles_d     = cycles_q;
    evt_valid_d  = evt_valid_q;
    evt_code_d   = evt_code_q;
    evt_cycles_d = evt_cycles_q;
    hit_total_d  = hit_total_q;
    case (state_q)
      ST_IDLE: begin
        if (count_i == '0) begin
          prev_d   = '0;
          cycles_d = '0;
        end
      end
      ST_TRACK: begin
        cycles_d = cycles_inc;
        if (evt_fire) begin
          evt_valid_d  = 1'b1;
          evt_code_d   = det_code;
          evt_cycles_d = cycles_inc;
        end else begin
          prev_d = count_i;
        end
      end
      ST_REPORT: begin
        if (handshake) begin
          evt_valid_d = 1'b0;
          evt_code_d  = EVT_NONE;
          if (evt_code_q == EVT_HIT) begin
            hit_total_d = hit_total_q + 8'd1;
          end
        end
      end
      default: begin
        evt_valid_d = 1'b0;
        evt_code_d  = EVT_NONE;
      end
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  always_comb begin
    evt_valid_o  = evt_valid_q;
    evt_code_o   = evt_code_q;
    evt_cycles_o = evt_cycles_q;
    hit_total_o  = hit_total_q;
    busy_o       = busy_q;
  end

endmodule

// File: tb/tb_count_max_monitor.sv
// Directed bench for count_max_monitor: two instances (MAX=8/TO=32 and MAX=0/TO=16) share
// stimulus; an event-level model is compared every cycle, plus hand-computed literal checks.
module tb_count_max_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] count;
  logic       ready;

  logic       a_vld, b_vld;
  logic [1:0] a_code, b_code;
  logic [7:0] a_cyc, b_cyc, a_hits, b_hits;
  logic       a_busy, b_busy;

  always #5 clk = ~clk;

  count_max_monitor #(.WIDTH(4), .MAX_VALUE(8), .TIMEOUT(32)) dut_a (
    .clk_i(clk), .reset_i(reset), .count_i(count),
    .evt_valid_o(a_vld), .evt_ready_i(ready), .evt_code_o(a_code),
    .evt_cycles_o(a_cyc), .hit_total_o(a_hits), .busy_o(a_busy)
  );

  count_max_monitor #(.WIDTH(4), .MAX_VALUE(0), .TIMEOUT(16)) dut_b (
    .clk_i(clk), .reset_i(reset), .count_i(count),
    .evt_valid_o(b_vld), .evt_ready_i(ready), .evt_code_o(b_code),
    .evt_cycles_o(b_cyc), .hit_total_o(b_hits), .busy_o(b_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Event-level model: 0=idle 1=watching 2=holding a record.
  int maxv[2] = '{8, 0};
  int tov[2]  = '{32, 16};
  int m_st[2], m_prev[2], m_n[2], m_vld[2], m_code[2], m_ecyc[2], m_hits[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int c, ev;
      c = int'(count);
      if (reset) begin
        m_st[i] = 0; m_prev[i] = 0; m_n[i] = 0; m_vld[i] = 0;
        m_code[i] = 0; m_ecyc[i] = 0; m_hits[i] = 0;
      end else if (m_st[i] == 0) begin
        if (c == 0) begin m_st[i] = 1; m_prev[i] = 0; m_n[i] = 0; end
      end else if (m_st[i] == 1) begin
        ev = 0;
        if (c != m_prev[i] && c != (m_prev[i] + 1) % 16) ev = 3;
        else if (c == maxv[i])                           ev = 1;
        else if (m_n[i] + 1 >= tov[i])                   ev = 2;
        m_n[i] = (m_n[i] + 1 > 255) ? 255 : m_n[i] + 1;
        if (ev != 0) begin
          m_st[i] = 2; m_vld[i] = 1; m_code[i] = ev; m_ecyc[i] = m_n[i];
        end else begin
          m_prev[i] = c;
        end
      end else if (ready) begin
        if (m_code[i] == 1) m_hits[i] = (m_hits[i] + 1) % 256;
        m_st[i] = 0; m_vld[i] = 0; m_code[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        int exp_v, act_v;
        exp_v = (m_vld[i] << 19) | (m_code[i] << 17) | (m_ecyc[i] << 9) |
                (m_hits[i] << 1) | ((m_st[i] != 0) ? 1 : 0);
        act_v = (i == 0) ? int'({a_vld, a_code, a_cyc, a_hits, a_busy})
                         : int'({b_vld, b_code, b_cyc, b_hits, b_busy});
        chk((i == 0) ? "model_a" : "model_b", act_v, exp_v);
      end
    end
  end

  task automatic drive(input int c);
    count = 4'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    count = 4'd9;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    count = 4'd0;
    ready = 1'b0;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", int'(a_vld), 0);
    chk("rst_code",  int'(a_code), 0);
    chk("rst_hits",  int'(a_hits), 0);
    chk("rst_busy",  int'(a_busy), 0);
    reset = 1'b0;

    // 1: clean run to MAX with the consumer always ready
    ready = 1'b1;
    for (int v = 0; v <= 7; v++) drive(v);
    chk("t1_busy_track", int'(a_busy), 1);
    chk("t1_no_evt_early", int'(a_vld), 0);
    drive(8);
    chk("t1_valid", int'(a_vld), 1);
    chk("t1_code",  int'(a_code), 1);
    chk("t1_cycles", int'(a_cyc), 8);
    drive(9);
    chk("t1_valid_one_cycle", int'(a_vld), 0);
    chk("t1_hits", int'(a_hits), 1);

    // 2: consumer stalls for 5 cycles
    do_reset();
    ready = 1'b0;
    for (int v = 0; v <= 8; v++) drive(v);
    for (int k = 0; k < 5; k++) begin
      drive(9);
      chk("t2_valid_held", int'(a_vld), 1);
      chk("t2_code_held", int'(a_code), 1);
      chk("t2_cycles_held", int'(a_cyc), 8);
    end
    ready = 1'b1;
    drive(9);
    chk("t2_valid_drop", int'(a_vld), 0);
    chk("t2_hits", int'(a_hits), 1);
    chk("t2_busy", int'(a_busy), 0);

    // 3: jump from 2 to 5
    do_reset();
    drive(0); drive(1); drive(2); drive(5);
    chk("t3_code", int'(a_code), 3);
    chk("t3_cycles", int'(a_cyc), 3);
    drive(9);
    chk("t3_hits", int'(a_hits), 0);

    // 4: stuck counter times out after 32 cycles of tracking
    do_reset();
    drive(0); drive(1); drive(2); drive(3);
    for (int n = 4; n <= 32; n++) begin
      drive(3);
      if (n == 31) chk("t4_no_evt_early", int'(a_vld), 0);
    end
    chk("t4_valid", int'(a_vld), 1);
    chk("t4_code", int'(a_code), 2);
    chk("t4_cycles", int'(a_cyc), 32);
    drive(9);

    // 5: HIT and JUMP in the same cycle -> JUMP
    do_reset();
    for (int v = 0; v <= 5; v++) drive(v);
    drive(8);
    chk("t5_code_jump", int'(a_code), 3);
    chk("t5_cycles", int'(a_cyc), 6);
    drive(9);
    chk("t5_hits", int'(a_hits), 0);

    // 5b: MAX=0 instance sees 15->0 wrap as legal; HIT coincides with TIMEOUT, HIT wins
    do_reset();
    drive(0);
    for (int v = 1; v <= 15; v++) drive(v);
    chk("t5b_no_evt", int'(b_vld), 0);
    drive(0);
    chk("t5b_valid", int'(b_vld), 1);
    chk("t5b_code_hit", int'(b_code), 1);
    chk("t5b_cycles", int'(b_cyc), 16);
    drive(9);
    chk("t5b_hits", int'(b_hits), 1);

    // 6: reset while a record is pending
    do_reset();
    for (int v = 0; v <= 8; v++) drive(v);
    drive(9);
    chk("t6_hits_before", int'(a_hits), 1);
    ready = 1'b0;
    for (int v = 0; v <= 8; v++) drive(v);
    chk("t6_pending", int'(a_vld), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_valid", int'(a_vld), 0);
    chk("t6_code", int'(a_code), 0);
    chk("t6_hits", int'(a_hits), 0);
    chk("t6_busy", int'(a_busy), 0);
    reset = 1'b0;
    drive(9);
    drive(9);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
